// File: rtl/framebuffer_pixel_writer.sv
// Pixel-stream sink: maps (x, y) to a linear framebuffer address, queues writes in a
// small FIFO and drives the BRAM write port; also runs a background clear engine.
module framebuffer_pixel_writer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 180,
    parameter int X_BITS     = 9,
    parameter int Y_BITS     = 8,
    parameter int ADDR_BITS  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_valid,
    input  logic [X_BITS-1:0]    pix_x,
    input  logic [Y_BITS-1:0]    pix_y,
    input  logic [15:0]          pix_value,
    input  logic                 frame_start,
    input  logic                 clear_start,
    input  logic [15:0]          clear_value,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_data,
    input  logic                 mem_grant,
    output logic                 busy,
    output logic                 overflow,
    output logic                 range_err,
    output logic [ADDR_BITS:0]   pixels_written,
    output logic                 frame_done
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int TOTAL    = WIDTH * HEIGHT;

    localparam logic [ADDR_BITS:0]   TOTAL_CNT = (ADDR_BITS+1)'(TOTAL);
    localparam logic [ADDR_BITS:0]   ONE_CNT   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(TOTAL - 1);
    localparam logic [ADDR_BITS-1:0] WIDTH_A   = ADDR_BITS'(WIDTH);
    localparam logic [X_BITS:0]      X_LIM     = (X_BITS+1)'(WIDTH);
    localparam logic [Y_BITS:0]      Y_LIM     = (Y_BITS+1)'(HEIGHT);
    localparam logic [PTR_BITS:0]    DEPTH_CNT = (PTR_BITS+1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                state_q, state_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_BITS-1:0]  s1_addr_q, s1_addr_d;
    logic [15:0]           s1_data_q, s1_data_d;
    logic [ADDR_BITS-1:0]  fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]  fifo_addr_d [FIFO_DEPTH];
    logic [15:0]           fifo_data_q [FIFO_DEPTH];
    logic [15:0]           fifo_data_d [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]     count_q, count_d;
    logic [ADDR_BITS-1:0]  clear_cnt_q, clear_cnt_d;
    logic [15:0]           clear_val_q, clear_val_d;
    logic [ADDR_BITS:0]    pix_cnt_q, pix_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  range_err_q, range_err_d;
    logic                  frame_done_q, frame_done_d;
    logic [ADDR_BITS-1:0]  last_addr_q, last_addr_d;
    logic [15:0]           last_data_q, last_data_d;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  in_range;
    logic [ADDR_BITS-1:0]  live_addr;
    logic [15:0]           live_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    // A full FIFO still accepts the stage-1 entry when the head leaves in the same cycle.
    assign push       = s1_valid_q && (!fifo_full || pop);
    assign in_range   = ({1'b0, pix_x} < X_LIM) && ({1'b0, pix_y} < Y_LIM);

    always_comb begin
        s1_valid_d = pix_valid && in_range;
        s1_addr_d  = s1_addr_q;
        s1_data_d  = s1_data_q;
        if (pix_valid && in_range) begin
            s1_addr_d = ADDR_BITS'(pix_y) * WIDTH_A + ADDR_BITS'(pix_x);
            s1_data_d = pix_value;
        end
    end

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = s1_addr_q;
            fifo_data_d[wr_ptr_q] = s1_data_q;
            wr_ptr_d              = wr_ptr_q + PTR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_BITS+1)'(1);
            2'b01:   count_d = count_q - (PTR_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        clear_val_d = clear_val_q;
        pop         = 1'b0;
        mem_we      = 1'b0;
        live_addr   = fifo_addr_q[rd_ptr_q];
        live_data   = fifo_data_q[rd_ptr_q];
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    mem_we = 1'b1;
                    pop    = mem_grant;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                live_addr = clear_cnt_q;
                live_data = clear_val_q;
                if (mem_grant) begin
                    if (clear_cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end else begin
                        clear_cnt_d = clear_cnt_q + ADDR_BITS'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new clear request always wins, including one that restarts a clear in flight.
        if (clear_start) begin
            state_d     = ST_CLEAR;
            clear_cnt_d = '0;
            clear_val_d = clear_value;
        end
        mem_addr    = mem_we ? live_addr : last_addr_q;
        mem_data    = mem_we ? live_data : last_data_q;
        last_addr_d = mem_addr;
        last_data_d = mem_data;
    end

    always_comb begin
        pix_cnt_d   = frame_start ? '0 : pix_cnt_q;
        overflow_d  = frame_start ? 1'b0 : overflow_q;
        range_err_d = frame_start ? 1'b0 : range_err_q;
        if (pop && (pix_cnt_d != TOTAL_CNT)) begin
            pix_cnt_d = pix_cnt_d + ONE_CNT;
        end
        // Events in the frame_start cycle belong to the new frame.
        if (s1_valid_q && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (pix_valid && !in_range) begin
            range_err_d = 1'b1;
        end
        frame_done_d = pop && (pix_cnt_d == TOTAL_CNT) && (frame_start || (pix_cnt_q != TOTAL_CNT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_data_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            clear_cnt_q  <= '0;
            clear_val_q  <= '0;
            pix_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            range_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_data_q    <= s1_data_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_data_q  <= fifo_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            clear_cnt_q  <= clear_cnt_d;
            clear_val_q  <= clear_val_d;
            pix_cnt_q    <= pix_cnt_d;
            overflow_q   <= overflow_d;
            range_err_q  <= range_err_d;
            frame_done_q <= frame_done_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
        end
    end

    assign busy           = (state_q == ST_CLEAR) || s1_valid_q || !fifo_empty;
    assign overflow       = overflow_q;
    assign range_err      = range_err_q;
    assign pixels_written = pix_cnt_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_framebuffer_pixel_writer.sv
// Randomized bench for framebuffer_pixel_writer on a 4x2 screen, checked against a
// transaction-level model (queue FIFO, clear cursor, frame counters, shadow framebuffer).
module tb_framebuffer_pixel_writer;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int XB  = 3;
    localparam int YB  = 2;
    localparam int AB  = 3;
    localparam int D   = 4;
    localparam int TOT = W * H;

    logic          clk;
    logic          rst_n;
    logic          pix_valid;
    logic [XB-1:0] pix_x;
    logic [YB-1:0] pix_y;
    logic [15:0]   pix_value;
    logic          frame_start;
    logic          clear_start;
    logic [15:0]   clear_value;
    logic          mem_we;
    logic [AB-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_grant;
    logic          busy;
    logic          overflow;
    logic          range_err;
    logic [AB:0]   pixels_written;
    logic          frame_done;

    framebuffer_pixel_writer #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB), .ADDR_BITS(AB), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_value(pix_value), .frame_start(frame_start), .clear_start(clear_start),
        .clear_value(clear_value), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_grant(mem_grant), .busy(busy), .overflow(overflow), .range_err(range_err),
        .pixels_written(pixels_written), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int fd_seen;

    // reference model state
    bit          m_s1_v;
    int          m_s1_a;
    logic [15:0] m_s1_d;
    int          m_qa[$];
    logic [15:0] m_qd[$];
    bit          m_clr;
    int          m_ccnt;
    logic [15:0] m_cval;
    int          m_pw;
    bit          m_ovf, m_rerr, m_fdone, m_fired;
    int          m_last_a;
    logic [15:0] m_last_d;
    logic [15:0] m_fb [TOT];
    logic [15:0] dut_fb [TOT];
    int          log_a[$];
    logic [15:0] log_d[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1_v = 0; m_s1_a = 0; m_s1_d = '0;
        m_qa.delete(); m_qd.delete();
        m_clr = 0; m_ccnt = 0; m_cval = '0;
        m_pw = 0; m_ovf = 0; m_rerr = 0; m_fdone = 0; m_fired = 0;
        m_last_a = 0; m_last_d = '0;
    endtask

    task automatic cycle(input bit pv, input int px, input int py, input logic [15:0] val,
                         input bit fs, input bit cs, input logic [15:0] cv, input bit g);
        int          e_addr;
        logic [15:0] e_data;
        bit          e_we, e_busy, commit, fd_next, inr;
        @(negedge clk);
        e_we = m_clr || (m_qa.size() > 0);
        if (m_clr) begin
            e_addr = m_ccnt; e_data = m_cval;
        end else if (m_qa.size() > 0) begin
            e_addr = m_qa[0]; e_data = m_qd[0];
        end else begin
            e_addr = m_last_a; e_data = m_last_d;
        end
        e_busy = m_clr || m_s1_v || (m_qa.size() > 0);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), e_addr);
        chk("mem_data", 32'(mem_data), 32'(e_data));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("range_err", 32'(range_err), 32'(m_rerr));
        chk("pixels_written", 32'(pixels_written), m_pw);
        chk("frame_done", 32'(frame_done), 32'(m_fdone));
        if (frame_done) fd_seen++;

        pix_valid   = pv;
        pix_x       = XB'(px);
        pix_y       = YB'(py);
        pix_value   = val;
        frame_start = fs;
        clear_start = cs;
        clear_value = cv;
        mem_grant   = g;
        if (mem_we && g) begin
            dut_fb[mem_addr] = mem_data;
            log_a.push_back(int'(mem_addr));
            log_d.push_back(mem_data);
        end

        commit  = e_we && g;
        fd_next = 0;
        if (commit) m_fb[e_addr] = e_data;
        if (e_we) begin
            m_last_a = e_addr; m_last_d = e_data;
        end
        if (fs) begin
            m_pw = 0; m_ovf = 0; m_rerr = 0; m_fired = 0;
        end
        if (commit && !m_clr) begin
            void'(m_qa.pop_front());
            void'(m_qd.pop_front());
            if (m_pw < TOT) m_pw++;
            if (m_pw == TOT && !m_fired) begin
                fd_next = 1; m_fired = 1;
            end
        end
        if (m_s1_v) begin
            if (m_qa.size() < D) begin
                m_qa.push_back(m_s1_a); m_qd.push_back(m_s1_d);
            end else begin
                m_ovf = 1;
            end
        end
        inr    = (px < W) && (py < H);
        m_s1_v = pv && inr;
        m_s1_a = py * W + px;
        m_s1_d = val;
        if (pv && !inr) m_rerr = 1;
        if (cs) begin
            m_clr = 1; m_ccnt = 0; m_cval = cv;
        end else if (commit && m_clr) begin
            if (m_ccnt == TOT - 1) m_clr = 0;
            else m_ccnt++;
        end
        m_fdone = fd_next;
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'h0, 0, 0, 16'h0, g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pix_valid = 0; frame_start = 0; clear_start = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_range_err", 32'(range_err), 0);
        chk("rst_pixels_written", 32'(pixels_written), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gmode;
        int fd0;
        bit g;
        n_checks = 0; n_errors = 0; fd_seen = 0; gmode = 0;
        rst_n = 1'b0; pix_valid = 0; pix_x = '0; pix_y = '0; pix_value = '0;
        frame_start = 0; clear_start = 0; clear_value = '0; mem_grant = 0;
        for (int i = 0; i < TOT; i++) begin
            m_fb[i] = '0; dut_fb[i] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single pixel at (3,1)
        cycle(1, 3, 1, 16'hF800, 0, 0, 16'h0, 1);
        cycle(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);
        @(posedge clk); #1;
        chk("t2_we", 32'(mem_we), 1);
        chk("t2_addr", 32'(mem_addr), 7);
        chk("t2_data", 32'(mem_data), 32'h0000F800);
        cycle(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);
        @(posedge clk); #1;
        chk("t3_busy", 32'(busy), 0);
        chk("t3_pw", 32'(pixels_written), 1);

        // full frame, one pixel per cycle
        cycle(0, 0, 0, 16'h0, 1, 0, 16'h0, 1);
        log_a.delete(); log_d.delete();
        fd0 = fd_seen;
        for (int i = 0; i < TOT; i++) cycle(1, i % W, i / W, 16'(16'h1000 + i), 0, 0, 16'h0, 1);
        idle(6, 1);
        chk("frame_commits", log_a.size(), TOT);
        for (int i = 0; i < TOT && i < log_a.size(); i++) chk("frame_addr", log_a[i], i);
        chk("frame_done_once", fd_seen - fd0, 1);
        chk("frame_pw", 32'(pixels_written), TOT);

        // overflow with grant held low
        cycle(0, 0, 0, 16'h0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 6; i++) cycle(1, i % W, i / W, 16'(16'h2000 + i), 0, 0, 16'h0, 0);
        idle(2, 0);
        @(posedge clk); #1;
        chk("ovf_set", 32'(overflow), 1);
        log_a.delete(); log_d.delete();
        idle(8, 1);
        chk("ovf_commits", log_a.size(), 4);
        for (int i = 0; i < 4 && i < log_a.size(); i++) begin
            chk("ovf_addr", log_a[i], i);
            chk("ovf_data", 32'(log_d[i]), 32'(16'h2000 + i));
        end
        cycle(0, 0, 0, 16'h0, 1, 0, 16'h0, 1);
        @(posedge clk); #1;
        chk("ovf_cleared", 32'(overflow), 0);

        // out-of-range pixel
        log_a.delete(); log_d.delete();
        cycle(1, 4, 0, 16'hBEEF, 0, 0, 16'h0, 1);
        idle(3, 1);
        chk("range_err_set", 32'(range_err), 1);
        chk("range_no_write", log_a.size(), 0);
        chk("range_pw", 32'(pixels_written), 0);

        // clear with two pixels arriving mid-clear
        cycle(0, 0, 0, 16'h0, 1, 0, 16'h0, 1);
        log_a.delete(); log_d.delete();
        cycle(0, 0, 0, 16'h0, 0, 1, 16'h001F, 1);
        cycle(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);
        cycle(1, 1, 0, 16'hAAAA, 0, 0, 16'h0, 1);
        cycle(1, 2, 1, 16'h5555, 0, 0, 16'h0, 1);
        idle(10, 1);
        chk("clr_commits", log_a.size(), TOT + 2);
        for (int i = 0; i < TOT && i < log_a.size(); i++) begin
            chk("clr_addr", log_a[i], i);
            chk("clr_data", 32'(log_d[i]), 32'h001F);
        end
        if (log_a.size() == TOT + 2) begin
            chk("clr_pix0_addr", log_a[TOT], 1);
            chk("clr_pix0_data", 32'(log_d[TOT]), 32'hAAAA);
            chk("clr_pix1_addr", log_a[TOT+1], 6);
            chk("clr_pix1_data", 32'(log_d[TOT+1]), 32'h5555);
        end
        chk("clr_pw", 32'(pixels_written), 2);

        // reset mid-clear with pixels queued
        cycle(0, 0, 0, 16'h0, 0, 1, 16'h1234, 0);
        for (int i = 0; i < 3; i++) cycle(1, i, 1, 16'(16'h3000 + i), 0, 0, 16'h0, 0);
        idle(2, 0);
        do_reset();
        log_a.delete(); log_d.delete();
        idle(5, 1);
        chk("post_rst_no_we", log_a.size(), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(0, 49) == 0) gmode = int'($urandom_range(0, 2));
            case (gmode)
                0:       g = 1'b1;
                1:       g = ($urandom_range(0, 1) == 1);
                default: g = ($urandom_range(0, 9) == 0);
            endcase
            cycle(($urandom_range(0, 1) == 1), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                  16'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0),
                  16'($urandom), g);
        end
        idle(TOT + D + 4, 1);

        for (int i = 0; i < TOT; i++) chk("fb_contents", 32'(dut_fb[i]), 32'(m_fb[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/framebuffer_pixel_writer.md
# framebuffer_pixel_writer

Sink for the raytracing controller's pixel stream (valid, x, y, 16-bit RGB565 value). It converts each (x, y) pair to a linear framebuffer address, buffers writes in a small FIFO, and drives the write port of the framebuffer BRAM through a valid/grant handshake. It also provides a background clear engine and frame-completion status. The controller has no backpressure, so every valid pixel must be accepted, or counted as lost, on its valid cycle.

## Interface
Parameters:
- WIDTH, 320, screen width in pixels
- HEIGHT, 180, screen height in pixels
- X_BITS, 9, width of pix_x
- Y_BITS, 8, width of pix_y
- ADDR_BITS, 16, framebuffer address width (must hold WIDTH*HEIGHT-1)
- FIFO_DEPTH, 8, write FIFO entries (power of two)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  pixel present this cycle
- pix_x  in  X_BITS  pixel column
- pix_y  in  Y_BITS  pixel row
- pix_value  in  16  RGB565 pixel
- frame_start  in  1  pulse: clear pixels_written, overflow, range_err
- clear_start  in  1  pulse: start the background clear
- clear_value  in  16  fill value, sampled on clear_start
- mem_we  out  1  write request
- mem_addr  out  ADDR_BITS  write address
- mem_data  out  16  write data
- mem_grant  in  1  write commits in any cycle with mem_we && mem_grant
- busy  out  1  clearing, or a pixel is held in stage 1 or the FIFO
- overflow  out  1  sticky: a pixel was lost to a full FIFO
- range_err  out  1  sticky: a pixel had x>=WIDTH or y>=HEIGHT
- pixels_written  out  ADDR_BITS+1  committed pixel writes this frame, saturating at WIDTH*HEIGHT
- frame_done  out  1  one-cycle pulse at frame completion

All outputs reset to 0. On reset the FIFO is empty, stage 1 is invalid, and the state is IDLE.

## Operation
- Stage 1 (registered), on pix_valid:
  - If in range: latch addr = pix_y*WIDTH + pix_x (unsigned, ADDR_BITS) and pix_value.
  - If out of range: drop the pixel, set range_err, leave stage 1 invalid.
- Stage 2: a valid stage-1 entry pushes into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is discarded and overflow is set.
  - Push and pop in the same cycle when full is legal and loses nothing.
- State machine:
  - IDLE: when the FIFO is non-empty, mem_we=1 and mem_addr/mem_data show the FIFO head. On grant: pop, and pixels_written += 1 (saturating).
  - clear_start (any state) → CLEAR. clear_cnt <= 0 and clear_value is latched.
  - CLEAR: mem_we=1, mem_addr=clear_cnt, mem_data=latched value. clear_cnt increments on grant. Grant at WIDTH*HEIGHT-1 → IDLE.
  - During CLEAR, pixels keep entering stage 1 and the FIFO but are not popped, so they land after the clear and overwrite it.
  - clear_start while already in CLEAR restarts at address 0 with the new value.
- Clear writes never change pixels_written.
- frame_done pulses in the cycle after the commit that makes pixels_written equal WIDTH*HEIGHT. It pulses only once per frame.
- frame_start:
  - Zeroes pixels_written, overflow and range_err next cycle.
  - Does not flush the FIFO. A commit in the same cycle as frame_start counts toward the new frame (count becomes 1).
  - frame_start and clear_start may coincide; both take effect.
- With mem_we=0, mem_addr/mem_data hold their last value.

## Timing
- Pixel on cycle t, FIFO empty, IDLE: in FIFO after edge t+1; mem_we=1 with its address in cycle t+2. Back-to-back pixels with grant held sustain 1 write/cycle.
- mem_we stays high and its address/data are stable until granted. No mem_we-low bubbles while the FIFO is non-empty in IDLE.
- CLEAR with grant held: exactly WIDTH*HEIGHT cycles. Queued pixels start draining the cycle after the last clear grant.
- Asserting rst_n low mid-operation immediately zeroes all outputs and empties the FIFO. It is legal in any state.

## Test plan
(WIDTH=4, HEIGHT=2, FIFO_DEPTH=4 unless stated.)
- Single pixel, x=3, y=1, value 0xF800, grant held → mem_we in cycle t+2, addr 7, data 0xF800; pixels_written=1; busy low by t+3.
- Eight pixels, one per cycle covering every address, grant held → addresses 0..7 in order; frame_done pulses exactly once, the cycle after the 8th commit; pixels_written=8 and stays there.
- Grant held low, six consecutive pixels → first 4 queued, pixels 5 and 6 lost; overflow=1. Releasing grant writes 4 pixels in order. frame_start then clears overflow.
- Pixel x=4, y=0 → no write; range_err=1; pixels_written unchanged.
- clear_start with value 0x001F, plus 2 pixels during the clear, grant held → addresses 0..7 written with 0x001F, then the 2 pixels. pixels_written=2.
- rst_n pulsed low mid-CLEAR with 3 pixels queued → all outputs 0, busy=0, and no further mem_we after release.
